// File: rtl/disp_mux_pkg.sv
// Shared constants and the scan state type for the multi-channel display multiplexer.
package disp_mux_pkg;

    localparam logic [31:0] DISP_RST_VAL  = 32'hAA5555AA;
    localparam logic [7:0]  BLINK_RST_VAL = 8'hFF;
    localparam logic [7:0]  POINT_RST_VAL = 8'h00;

    typedef enum logic {
        MANUAL,
        SCAN
    } scan_state_t;

endpackage

// File: rtl/disp_scan_ctrl.sv
// Channel selection for the display mux: manual select or auto-scan with dwell counter,
// hold and an optional channel-enable mask (all-ones mask when the feature is absent).
module disp_scan_ctrl
    import disp_mux_pkg::*;
#(
    parameter int unsigned NCH     = 8,
    parameter int unsigned DWELL_W = 24,
    parameter int unsigned SW      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               hold,
    input  logic [SW-1:0]      sel,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NCH-1:0]     ch_mask,
    output logic [SW-1:0]      o_ch_nxt,
    output logic               o_scan_tick
);

    scan_state_t        r_state, w_state_nxt;
    logic [DWELL_W-1:0] r_cnt, w_cnt_nxt, w_limit;
    logic [SW-1:0]      r_ptr, w_ptr_nxt, w_sel_ok, w_start, w_step;
    logic               r_tick, w_adv, w_any;

    // First mask-enabled channel at base+first, searching upward with wrap.
    function automatic logic [SW-1:0] f_search(input logic [SW-1:0] base,
                                               input int unsigned first,
                                               input logic [NCH-1:0] m);
        logic [SW-1:0]  r;
        logic           found;
        int unsigned    idx;
        logic [NCH-1:0] sh;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = (32'(base) + first + i) % NCH;
            sh  = m >> idx;
            if (!found && sh[0]) begin
                r     = SW'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign w_sel_ok = ({1'b0, sel} < (SW+1)'(NCH)) ? sel : '0;
    assign w_any    = |ch_mask;
    assign w_limit  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign w_start  = f_search(w_sel_ok, 0, ch_mask);
    assign w_step   = f_search(r_ptr, 1, ch_mask);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_adv       = 1'b0;
        case (r_state)
            MANUAL: begin
                w_cnt_nxt = '0;
                if (mode) begin
                    w_state_nxt = SCAN;
                    w_ptr_nxt   = w_any ? w_start : '0;
                end else begin
                    w_ptr_nxt = w_sel_ok;
                end
            end
            SCAN: begin
                if (!mode) begin
                    w_state_nxt = MANUAL;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_sel_ok;
                end else if (!w_any) begin
                    w_cnt_nxt = '0;
                    w_ptr_nxt = '0;
                end else if (!hold) begin
                    // >= so a dwell lowered below the running count advances at once
                    if (r_cnt >= w_limit) begin
                        w_adv     = 1'b1;
                        w_cnt_nxt = '0;
                        w_ptr_nxt = w_step;
                    end else begin
                        w_cnt_nxt = r_cnt + DWELL_W'(1);
                    end
                end
            end
            default: w_state_nxt = MANUAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= MANUAL;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_tick  <= w_adv;
        end
    end

    assign o_ch_nxt    = w_ptr_nxt;
    assign o_scan_tick = r_tick;

endmodule

// File: rtl/multi_nch_disp.sv
// NCH-channel display multiplexer with CPU channel 0, registered outputs and auto-scan.
// Optional CH_MASK_EN adds a ch_mask input restricting which channels auto-scan visits.
module multi_nch_disp
    import disp_mux_pkg::*;
#(
    parameter  int unsigned NCH     = 8,
    parameter  int unsigned DW      = 32,
    parameter  int unsigned PW      = 8,
    parameter  int unsigned DWELL_W = 24,
    localparam int unsigned SW      = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               EN,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    input  logic               hold,
    input  logic [DWELL_W-1:0] dwell,
`ifdef CH_MASK_EN
    input  logic [NCH-1:0]     ch_mask,
`endif
    input  logic [NCH*DW-1:0]  data_in,
    input  logic [NCH*PW-1:0]  point_in,
    input  logic [NCH*PW-1:0]  blink_in,
    output logic [DW-1:0]      Disp_num,
    output logic [PW-1:0]      point_out,
    output logic [PW-1:0]      blink_out,
    output logic [SW-1:0]      ch_active,
    output logic               scan_tick
);

    logic [DW-1:0]  r_cpu_data, w_data;
    logic [PW-1:0]  r_cpu_point, r_cpu_blink, w_point, w_blink;
    logic [SW-1:0]  w_ch;
    logic [NCH-1:0] w_mask;

`ifdef CH_MASK_EN
    assign w_mask = ch_mask;
`else
    assign w_mask = '1;
`endif

    disp_scan_ctrl #(
        .NCH     (NCH),
        .DWELL_W (DWELL_W),
        .SW      (SW)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .hold        (hold),
        .sel         (sel),
        .dwell       (dwell),
        .ch_mask     (w_mask),
        .o_ch_nxt    (w_ch),
        .o_scan_tick (scan_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cpu_data  <= DW'(DISP_RST_VAL);
            r_cpu_point <= PW'(POINT_RST_VAL);
            r_cpu_blink <= PW'(BLINK_RST_VAL);
        end else if (EN) begin
            r_cpu_data  <= data_in[DW-1:0];
            r_cpu_point <= point_in[PW-1:0];
            r_cpu_blink <= blink_in[PW-1:0];
        end
    end

    // Channel index is already range-checked by the controller; 0 means CPU regs.
    always_comb begin
        w_data  = r_cpu_data;
        w_point = r_cpu_point;
        w_blink = r_cpu_blink;
        for (int unsigned k = 1; k < NCH; k++) begin
            if (w_ch == SW'(k)) begin
                w_data  = data_in[k*DW +: DW];
                w_point = point_in[k*PW +: PW];
                w_blink = blink_in[k*PW +: PW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            Disp_num  <= DW'(DISP_RST_VAL);
            point_out <= PW'(POINT_RST_VAL);
            blink_out <= PW'(BLINK_RST_VAL);
            ch_active <= '0;
        end else begin
            Disp_num  <= w_data;
            point_out <= w_point;
            blink_out <= w_blink;
            ch_active <= w_ch;
        end
    end

endmodule

// File: tb/tb_multi_nch_disp.sv
// Directed self-checking bench for multi_nch_disp (NCH=8 and NCH=10 instances).
module tb_multi_nch_disp;

    logic clk = 1'b0;
    logic rst, en, mode, hold;
    logic [2:0]   sel;
    logic [23:0]  dwell;
    logic [255:0] data_in;
    logic [63:0]  point_in, blink_in;
    logic [31:0]  disp;
    logic [7:0]   point_o, blink_o;
    logic [2:0]   ch;
    logic         tick;

    logic         en10, mode10, hold10;
    logic [3:0]   sel10;
    logic [319:0] data10;
    logic [79:0]  point10, blink10;
    logic [31:0]  disp10;
    logic [7:0]   point_o10, blink_o10;
    logic [3:0]   ch10;
    logic         tick10;
`ifdef CH_MASK_EN
    logic [7:0]   mask8;
    logic [9:0]   mask10;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_nch_disp u8 (
        .clk(clk), .rst(rst), .EN(en), .mode(mode), .sel(sel), .hold(hold), .dwell(dwell),
`ifdef CH_MASK_EN
        .ch_mask(mask8),
`endif
        .data_in(data_in), .point_in(point_in), .blink_in(blink_in),
        .Disp_num(disp), .point_out(point_o), .blink_out(blink_o),
        .ch_active(ch), .scan_tick(tick)
    );

    multi_nch_disp #(.NCH(10)) u10 (
        .clk(clk), .rst(rst), .EN(en10), .mode(mode10), .sel(sel10), .hold(hold10), .dwell(dwell),
`ifdef CH_MASK_EN
        .ch_mask(mask10),
`endif
        .data_in(data10), .point_in(point10), .blink_in(blink10),
        .Disp_num(disp10), .point_out(point_o10), .blink_out(blink_o10),
        .ch_active(ch10), .scan_tick(tick10)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        if (disp !== 32'hAA5555AA) begin bad++; $display("FAIL rst_disp got=%h exp=AA5555AA", disp); end
        total++;
        if (blink_o !== 8'hFF) begin bad++; $display("FAIL rst_blink got=%h exp=FF", blink_o); end
        total++;
        if (point_o !== 8'h00) begin bad++; $display("FAIL rst_point got=%h exp=00", point_o); end
        total++;
        if (ch !== 3'd0 || tick !== 1'b0) begin bad++; $display("FAIL rst_ch got=%0d/%b exp=0/0", ch, tick); end
        total++;
        rst = 1'b1;
        step();
        if (disp !== 32'hAA5555AA || blink_o !== 8'hFF || point_o !== 8'h00) begin
            bad++; $display("FAIL release_out got=%h/%h/%h exp=AA5555AA/00/FF", disp, point_o, blink_o);
        end
        total++;
    endtask

    task automatic test_cpu_write();
        data_in[31:0] = 32'h12345678;
        point_in[7:0] = 8'h3C;
        blink_in[7:0] = 8'h81;
        en = 1'b1;
        step();
        en = 1'b0;
        if (disp !== 32'hAA5555AA) begin bad++; $display("FAIL cpu_early got=%h exp=AA5555AA", disp); end
        total++;
        step();
        if (disp !== 32'h12345678 || point_o !== 8'h3C || blink_o !== 8'h81) begin
            bad++; $display("FAIL cpu_write got=%h/%h/%h exp=12345678/3C/81", disp, point_o, blink_o);
        end
        total++;
        data_in[31:0] = 32'h0BADF00D;
        step();
        step();
        if (disp !== 32'h12345678) begin bad++; $display("FAIL cpu_hold got=%h exp=12345678", disp); end
        total++;
    endtask

    task automatic test_manual();
        sel = 3'd3;
        data_in[3*32 +: 32] = 32'hDEADBEEF;
        point_in[3*8 +: 8]  = 8'h0F;
        step();
        if (disp !== 32'hDEADBEEF || point_o !== 8'h0F || ch !== 3'd3) begin
            bad++; $display("FAIL man_sel3 got=%h/%h/%0d exp=DEADBEEF/0F/3", disp, point_o, ch);
        end
        total++;
        data_in[3*32 +: 32] = 32'hCAFEF00D;
        step();
        if (disp !== 32'hCAFEF00D) begin bad++; $display("FAIL man_live got=%h exp=CAFEF00D", disp); end
        total++;
        if (tick !== 1'b0) begin bad++; $display("FAIL man_tick got=%b exp=0", tick); end
        total++;
        sel10 = 4'd9;
        data10[9*32 +: 32] = 32'h99990009;
        step();
        if (disp10 !== 32'h99990009 || ch10 !== 4'd9) begin
            bad++; $display("FAIL n10_sel9 got=%h/%0d exp=99990009/9", disp10, ch10);
        end
        total++;
        sel10 = 4'd12;
        step();
        if (disp10 !== 32'hAA5555AA || blink_o10 !== 8'hFF || ch10 !== 4'd0) begin
            bad++; $display("FAIL n10_sel12 got=%h/%h/%0d exp=AA5555AA/FF/0", disp10, blink_o10, ch10);
        end
        total++;
    endtask

    task automatic test_scan();
        logic [2:0]  e_ch;
        logic        e_tick;
        logic [31:0] e_disp;
        for (int k = 1; k < 8; k++) data_in[k*32 +: 32] = 32'h10000000 + k;
        mode = 1'b0; sel = 3'd6; dwell = 24'd4;
        step();
        mode = 1'b1;
        for (int j = 0; j < 16; j++) begin
            step();
            e_ch   = 3'((6 + j / 4) % 8);
            e_tick = (j % 4 == 0) && (j > 0);
            e_disp = (e_ch == 3'd0) ? 32'h12345678 : 32'h10000000 + 32'(e_ch);
            if (ch !== e_ch || tick !== e_tick || disp !== e_disp) begin
                bad++; $display("FAIL scan_d4 j=%0d got=%0d/%b/%h exp=%0d/%b/%h", j, ch, tick, disp, e_ch, e_tick, e_disp);
            end
            total++;
        end
        dwell = 24'd0;
        for (int i = 1; i <= 5; i++) begin
            step();
            e_ch = 3'((1 + i) % 8);
            if (ch !== e_ch || tick !== 1'b1) begin
                bad++; $display("FAIL scan_d0 i=%0d got=%0d/%b exp=%0d/1", i, ch, tick, e_ch);
            end
            total++;
        end
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) data_in[6*32 +: 32] = 32'hABCD0006;
            step();
            e_disp = (i >= 5) ? 32'hABCD0006 : 32'h10000006;
            if (ch !== 3'd6 || tick !== 1'b0 || disp !== e_disp) begin
                bad++; $display("FAIL hold i=%0d got=%0d/%b/%h exp=6/0/%h", i, ch, tick, disp, e_disp);
            end
            total++;
        end
        hold = 1'b0;
        step();
        if (ch !== 3'd7 || tick !== 1'b1) begin bad++; $display("FAIL unhold got=%0d/%b exp=7/1", ch, tick); end
        total++;
        dwell = 24'd5;
        step();
        step();
        if (ch !== 3'd7 || tick !== 1'b0) begin bad++; $display("FAIL dwell5 got=%0d/%b exp=7/0", ch, tick); end
        total++;
        dwell = 24'd2;
        step();
        if (ch !== 3'd0 || tick !== 1'b1 || disp !== 32'h12345678) begin
            bad++; $display("FAIL dwell_shrink got=%0d/%b/%h exp=0/1/12345678", ch, tick, disp);
        end
        total++;
        rst = 1'b0;
        step();
        if (ch !== 3'd0 || tick !== 1'b0 || disp !== 32'hAA5555AA || blink_o !== 8'hFF) begin
            bad++; $display("FAIL scan_rst got=%0d/%b/%h/%h exp=0/0/AA5555AA/FF", ch, tick, disp, blink_o);
        end
        total++;
        rst = 1'b1;
        step();
        if (ch !== 3'd6 || tick !== 1'b0 || disp !== 32'hABCD0006) begin
            bad++; $display("FAIL scan_restart got=%0d/%b/%h exp=6/0/ABCD0006", ch, tick, disp);
        end
        total++;
        mode = 1'b0; sel = 3'd2;
        step();
        if (ch !== 3'd2 || disp !== 32'h10000002) begin
            bad++; $display("FAIL back_manual got=%0d/%h exp=2/10000002", ch, disp);
        end
        total++;
    endtask

`ifdef CH_MASK_EN
    task automatic test_mask();
        logic [2:0] exp_seq [4];
        exp_seq = '{3'd2, 3'd5, 3'd7, 3'd2};
        mask8 = 8'b1010_0100;
        mode = 1'b0; sel = 3'd0; dwell = 24'd1;
        step();
        mode = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            if (ch !== exp_seq[j] || tick !== (j > 0)) begin
                bad++; $display("FAIL mask_seq j=%0d got=%0d/%b exp=%0d/%b", j, ch, tick, exp_seq[j], j > 0);
            end
            total++;
        end
        mask8 = 8'h00;
        for (int j = 0; j < 3; j++) begin
            step();
            if (ch !== 3'd0 || tick !== 1'b0) begin
                bad++; $display("FAIL mask_zero j=%0d got=%0d/%b exp=0/0", j, ch, tick);
            end
            total++;
        end
        mode = 1'b0; sel = 3'd3;
        step();
        if (ch !== 3'd3) begin bad++; $display("FAIL mask_manual got=%0d exp=3", ch); end
        total++;
        mask8 = '1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; en = 1'b0; mode = 1'b0; hold = 1'b0; sel = '0; dwell = '0;
        data_in = '0; point_in = '0; blink_in = '0;
        en10 = 1'b0; mode10 = 1'b0; hold10 = 1'b0; sel10 = '0;
        data10 = '0; point10 = '0; blink10 = '0;
`ifdef CH_MASK_EN
        mask8 = '1; mask10 = '1;
`endif
        test_reset();
        test_cpu_write();
        test_manual();
        test_scan();
`ifdef CH_MASK_EN
        test_mask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
